// File: rtl/nb_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nb_isa_pkg
// Purpose  : Instruction word layout shared by the fetch and parse stages:
//            field widths, the HALT opcode, field-slice helpers and the
//            fetch sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
package nb_isa_pkg;

  localparam int OP_SIZE      = 4;
  localparam int PARAM_A_SIZE = 4;
  localparam int PARAM_B_SIZE = 4;
  localparam int CODE_W       = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE;

  localparam logic [OP_SIZE-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Opcode lives in the MSBs of the word.
  function automatic logic [OP_SIZE-1:0] get_op(input logic [CODE_W-1:0] word);
    return word[CODE_W-1 -: OP_SIZE];
  endfunction

  function automatic logic [PARAM_A_SIZE-1:0] get_param_a(input logic [CODE_W-1:0] word);
    return word[PARAM_A_SIZE+PARAM_B_SIZE-1 -: PARAM_A_SIZE];
  endfunction

  // Second parameter occupies the LSBs.
  function automatic logic [PARAM_B_SIZE-1:0] get_param_b(input logic [CODE_W-1:0] word);
    return word[PARAM_B_SIZE-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem
// Purpose  : DEPTH x DATA_W program RAM, one synchronous write port and one
//            synchronous read port with a single cycle of read latency.
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage array is never cleared; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read register only updates on an explicit read so the word stays stable
  // while the consumer stalls; reset clears it to present an all-zero word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Program sequencer feeding the instruction parse stage. Holds a
//            host-loaded program, steps a PC and issues one word per
//            valid/ready handshake until a HALT opcode or end of memory.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int OP_SIZE      = nb_isa_pkg::OP_SIZE,
  parameter int PARAM_A_SIZE = nb_isa_pkg::PARAM_A_SIZE,
  parameter int PARAM_B_SIZE = nb_isa_pkg::PARAM_B_SIZE,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        load_en,
  input  logic [ADDR_W-1:0]                           load_addr,
  input  logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] load_data,
  input  logic                                        start,
  output logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] code,
  output logic                                        code_valid,
  input  logic                                        code_ready,
  output logic [ADDR_W-1:0]                           pc,
  output logic                                        busy,
  output logic                                        halted,
  output logic                                        overrun
);

  import nb_isa_pkg::*;

  localparam int                c_code_w  = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE;
  localparam logic [OP_SIZE-1:0] c_op_halt = OP_SIZE'(OP_HALT);
  localparam logic [ADDR_W-1:0]  c_last_pc = ADDR_W'(DEPTH - 1);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                r_overrun;
  logic                w_overrun_nxt;
  logic                w_rd_en;
  logic [c_code_w-1:0] w_rd_data;
  logic                w_handshake;
  logic                w_is_halt;

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (c_code_w)
  ) u_prog_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (load_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (w_rd_en),
    .rd_addr (r_pc),
    .rd_data (w_rd_data)
  );

  assign w_handshake = (r_state == ISSUE) && code_ready;
  assign w_is_halt   = (w_rd_data[c_code_w-1 -: OP_SIZE] == c_op_halt);

  // State, PC and sticky overrun flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Next-state logic: launch the read in FETCH, wait for the handshake in
  // ISSUE, then either stop (HALT opcode / last word) or advance the PC.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_overrun_nxt = r_overrun;
    w_rd_en       = 1'b0;
    unique case (r_state)
      IDLE, HALT: begin
        if (start) begin
          w_state_nxt   = FETCH;
          w_pc_nxt      = '0;
          w_overrun_nxt = 1'b0;
        end
      end
      FETCH: begin
        w_rd_en     = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (w_handshake) begin
          if (w_is_halt) begin
            w_state_nxt = HALT;
          end else if (r_pc == c_last_pc) begin
            w_state_nxt   = HALT;
            w_overrun_nxt = 1'b1;
          end else begin
            w_state_nxt = FETCH;
            w_pc_nxt    = r_pc + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign code       = w_rd_data;
  assign code_valid = (r_state == ISSUE);
  assign pc         = r_pc;
  assign busy       = (r_state == FETCH) || (r_state == ISSUE);
  assign halted     = (r_state == HALT);
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch against a program-level
//            reference model (expected issue list derived from the image).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_data;
  logic        start;
  logic        code_ready;
  logic [11:0] code;
  logic        code_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  logic [11:0] prog_img [DEPTH];
  logic [11:0] exp_code [$];
  logic [3:0]  exp_pc   [$];
  logic        exp_ovr;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .overrun    (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int a, input logic [11:0] d);
    load_en   = 1'b1;
    load_addr = a[3:0];
    load_data = d;
    prog_img[a] = d;
    tick();
    load_en = 1'b0;
  endtask

  // Program-level model: execution walks addresses from 0, issuing each word,
  // until a word with opcode F has been issued or the last address is issued.
  function automatic void build_model();
    exp_code.delete();
    exp_pc.delete();
    exp_ovr = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      exp_code.push_back(prog_img[a]);
      exp_pc.push_back(a[3:0]);
      if (prog_img[a][11:8] == 4'hF) return;
    end
    exp_ovr = 1'b1;
  endfunction

  // Start the program and consume it; hold_idx/hold_n force code_ready low
  // for hold_n cycles while that issue is presented.
  task automatic run_program(input int ready_pct, input int hold_idx, input int hold_n);
    int idx    = 0;
    int held   = 0;
    int cycles = 0;
    bit gap    = 1'b1;
    bit first  = 1'b1;
    bit done   = 1'b0;
    bit r;
    build_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && cycles < 400) begin
      if (gap) begin
        check("fetch_gap", {29'd0, code_valid, busy, halted}, 32'b010);
        if (first) begin
          check("start_ovr_clear", {31'd0, overrun}, 32'd0);
          first = 1'b0;
        end
        code_ready = 1'($urandom_range(1));
        gap = 1'b0;
      end else begin
        check("issue_valid", {31'd0, code_valid}, 32'd1);
        check("issue_code", {20'd0, code}, {20'd0, exp_code[idx]});
        check("issue_pc", {28'd0, pc}, {28'd0, exp_pc[idx]});
        if (idx == hold_idx && held < hold_n) begin
          r = 1'b0;
          held++;
        end else begin
          r = (int'($urandom_range(99)) < ready_pct);
        end
        code_ready = r;
        if (r) begin
          idx++;
          if (idx == exp_code.size()) done = 1'b1;
          else gap = 1'b1;
        end
      end
      tick();
      cycles++;
    end
    code_ready = 1'b0;
    if (!done) check("run_timeout", 32'd0, 32'd1);
    check("end_halted", {31'd0, halted}, 32'd1);
    check("end_valid", {31'd0, code_valid}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    check("end_pc_hold", {28'd0, pc}, {28'd0, exp_pc[exp_pc.size()-1]});
  endtask

  initial begin
    bit found;
    for (int a = 0; a < DEPTH; a++) prog_img[a] = 12'h000;
    rst        = 1'b1;
    load_en    = 1'b0;
    load_addr  = 4'd0;
    load_data  = 12'd0;
    start      = 1'b0;
    code_ready = 1'b0;

    // Reset then idle.
    tick();
    tick();
    rst = 1'b0;
    check("rst_code", {20'd0, code}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", {25'd0, code_valid, pc, halted, busy}, 32'd0);
    end

    // Basic run.
    load_word(0, 12'h123);
    load_word(1, 12'h4A5);
    load_word(2, 12'hF00);
    run_program(100, -1, 0);

    // Backpressure on the second instruction.
    run_program(100, 1, 5);

    // Overrun: no HALT anywhere.
    for (int a = 0; a < DEPTH; a++) load_word(a, 12'h111);
    run_program(100, -1, 0);

    // Restart from HALT with overrun set.
    run_program(100, -1, 0);

    // Start during ISSUE is ignored; reset mid-issue discards the word.
    start = 1'b1;
    tick();
    start = 1'b0;
    code_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (code_valid && pc == 4'd3) found = 1'b1;
      else tick();
    end
    code_ready = 1'b0;
    check("seek_pc3", {31'd0, found}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_issue_pc", {28'd0, pc}, 32'd3);
    check("start_in_issue_valid", {31'd0, code_valid}, 32'd1);
    tick();
    tick();
    check("stall_code", {20'd0, code}, 32'h111);
    check("stall_pc", {28'd0, pc}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_state", {25'd0, code_valid, pc, halted, busy}, 32'd0);
    check("rst_mid_code", {20'd0, code}, 32'd0);
    run_program(100, -1, 0);

    // Reset and start together: reset wins, start is not remembered.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_idle", {29'd0, code_valid, busy, halted}, 32'd0);
    tick();
    check("rst_start_stay", {29'd0, code_valid, busy, halted}, 32'd0);

    // Random programs with random backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < DEPTH; a++) load_word(a, 12'($urandom_range(4095)));
      run_program(60, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
